// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line I-cache,
// static JAL prediction, and a request/acknowledge miss path toward memory.
module if_fetch #(
    parameter int          ICACHE_ENTRIES = 16,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic [31:0] prediction_o
);

    localparam int          IW  = $clog2(ICACHE_ENTRIES);
    localparam int          TW  = 30 - IW;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOOKUP = 2'd0,
        ST_MISS   = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                     state_r, state_s;
    logic [31:0]                pc_r, pc_s;
    logic [31:0]                target_r, target_s;
    logic                       req_r, req_s;
    logic [31:0]                addr_r, addr_s;
    logic [31:0]                out_pc_r, out_pc_s;
    logic [31:0]                out_inst_r, out_inst_s;
    logic                       out_valid_r, out_valid_s;
    logic [31:0]                out_pred_r, out_pred_s;
    logic                       fill_s;

    logic [ICACHE_ENTRIES-1:0]  valid_r;
    logic [TW-1:0]              tag_mem  [ICACHE_ENTRIES];
    logic [31:0]                data_mem [ICACHE_ENTRIES];

    logic [IW-1:0]              lk_idx_s;
    logic [IW-1:0]              fill_idx_s;
    logic                       hit_s;
    logic [31:0]                hit_pred_s;
    logic [31:0]                fill_pred_s;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Static predictor: JAL target when the opcode matches, else fall through.
    function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] imm;
        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        if (inst[6:0] == 7'b1101111) begin
            return pc + imm;
        end else begin
            return pc + 32'd4;
        end
    endfunction

    assign lk_idx_s    = pc_r[IW+1:2];
    assign fill_idx_s  = addr_r[IW+1:2];
    assign hit_s       = valid_r[lk_idx_s] && (tag_mem[lk_idx_s] == pc_r[31:IW+2]);
    assign hit_pred_s  = predict(pc_r, data_mem[lk_idx_s]);
    assign fill_pred_s = predict(pc_r, mem_data_i);

    // Next-state and next-output selection for the fetch FSM.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        target_s    = target_r;
        req_s       = req_r;
        addr_s      = addr_r;
        out_pc_s    = out_pc_r;
        out_inst_s  = out_inst_r;
        out_valid_s = out_valid_r;
        out_pred_s  = out_pred_r;
        fill_s      = 1'b0;
        case (state_r)
            ST_LOOKUP: begin
                if (jump_i) begin
                    pc_s        = word_align(jump_addr_i);
                    out_valid_s = 1'b0;
                    out_inst_s  = NOP;
                end else if (stall_i) begin
                    pc_s = pc_r;
                end else if (hit_s) begin
                    out_pc_s    = pc_r;
                    out_inst_s  = data_mem[lk_idx_s];
                    out_valid_s = 1'b1;
                    out_pred_s  = hit_pred_s;
                    pc_s        = hit_pred_s;
                end else begin
                    // Present a bubble while the miss is serviced so decode never re-consumes.
                    state_s     = ST_MISS;
                    req_s       = 1'b1;
                    addr_s      = pc_r;
                    out_valid_s = 1'b0;
                    out_inst_s  = NOP;
                end
            end
            ST_MISS: begin
                if (mem_ack_i) begin
                    fill_s  = 1'b1;
                    req_s   = 1'b0;
                    state_s = ST_LOOKUP;
                    if (jump_i) begin
                        pc_s        = word_align(jump_addr_i);
                        out_valid_s = 1'b0;
                        out_inst_s  = NOP;
                    end else if (stall_i) begin
                        pc_s = pc_r;
                    end else begin
                        out_pc_s    = pc_r;
                        out_inst_s  = mem_data_i;
                        out_valid_s = 1'b1;
                        out_pred_s  = fill_pred_s;
                        pc_s        = fill_pred_s;
                    end
                end else if (jump_i) begin
                    state_s     = ST_DRAIN;
                    target_s    = word_align(jump_addr_i);
                    out_valid_s = 1'b0;
                    out_inst_s  = NOP;
                end else begin
                    state_s = ST_MISS;
                end
            end
            ST_DRAIN: begin
                if (mem_ack_i) begin
                    fill_s  = 1'b1;
                    req_s   = 1'b0;
                    state_s = ST_LOOKUP;
                    pc_s    = jump_i ? word_align(jump_addr_i) : target_r;
                end else if (jump_i) begin
                    target_s = word_align(jump_addr_i);
                end else begin
                    target_s = target_r;
                end
            end
            default: begin
                state_s = ST_LOOKUP;
                req_s   = 1'b0;
            end
        endcase
    end

    // State, PC, request and output registers plus line valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOOKUP;
            pc_r        <= word_align(RESET_PC);
            target_r    <= 32'h0000_0000;
            req_r       <= 1'b0;
            addr_r      <= 32'h0000_0000;
            out_pc_r    <= 32'h0000_0000;
            out_inst_r  <= NOP;
            out_valid_r <= 1'b0;
            out_pred_r  <= 32'h0000_0000;
            valid_r     <= '0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            target_r    <= target_s;
            req_r       <= req_s;
            addr_r      <= addr_s;
            out_pc_r    <= out_pc_s;
            out_inst_r  <= out_inst_s;
            out_valid_r <= out_valid_s;
            out_pred_r  <= out_pred_s;
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents need no reset since valid bits gate them.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_mem[fill_idx_s]  <= addr_r[31:IW+2];
            data_mem[fill_idx_s] <= mem_data_i;
        end
    end

    assign mem_req_o    = req_r;
    assign mem_addr_o   = addr_r;
    assign pc_o         = out_pc_r;
    assign inst_o       = out_inst_r;
    assign inst_valid_o = out_valid_r;
    assign prediction_o = out_pred_r;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch scenarios, a latency-programmable
// memory responder checking request addresses, and a monitor comparing each new output.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [31:0] prediction_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pred;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lat    = 3;
    logic        jal8   = 1'b0;
    logic        edge_stall = 1'b0;

    if_fetch #(.ICACHE_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .prediction_o (prediction_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0010_0093;
            32'h0000_0004: return 32'h0020_0113;
            32'h0000_0008: return jal8 ? 32'h0100_006F : 32'h0000_8013;
            32'h0000_000C: return 32'h0030_0193;
            default:       return {a[19:0], 12'h013};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] i, input logic [31:0] n);
        exp_t e;
        e.pc   = p;
        e.inst = i;
        e.pred = n;
        exp_q.push_back(e);
    endtask

    // Remember whether the most recent edge was a stalled one.
    always @(posedge clk) edge_stall <= stall_i;

    // Monitor: every newly registered valid output is popped and compared.
    always @(negedge clk) begin
        if (inst_valid_o === 1'b1 && !edge_stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_extra actual=pc %h expected=no output", pc_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pc", pc_o, e.pc);
                check("out_inst", inst_o, e.inst);
                check("out_pred", prediction_o, e.pred);
            end
        end
    end

    // Memory responder: checks each request address, holds it, acks after lat cycles.
    initial begin
        int          cnt;
        logic        busy;
        logic [31:0] cur;
        busy       = 1'b0;
        cnt        = 0;
        cur        = 32'h0;
        mem_ack_i  = 1'b0;
        mem_data_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (mem_req_o !== 1'b1) begin
                busy = 1'b0;
            end else if (!busy) begin
                busy = 1'b1;
                cnt  = 0;
                cur  = mem_addr_o;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_extra actual=%h expected=no request", mem_addr_o);
                end else begin
                    check("req_addr", mem_addr_o, req_q.pop_front());
                end
            end else begin
                cnt++;
                check("req_hold", mem_addr_o, cur);
                if (cnt == lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem_word(cur);
                    busy       = 1'b0;
                end
            end
        end
    end

    initial begin
        int   k;
        logic found;
        rst         = 1'b1;
        stall_i     = 1'b0;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;

        for (int r = 0; r < 3; r++) begin
            push_exp(32'h0, 32'h0010_0093, 32'h4);
            push_exp(32'h4, 32'h0020_0113, 32'h8);
            push_exp(32'h8, 32'h0000_8013, 32'hC);
            push_exp(32'hC, 32'h0030_0193, 32'h10);
        end
        req_q.push_back(32'h0);
        req_q.push_back(32'h4);
        req_q.push_back(32'h8);
        req_q.push_back(32'hC);
        req_q.push_back(32'h10);

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_pred", prediction_o, 32'h0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        rst = 1'b0;

        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid_o) begin
                k = i;
                break;
            end
        end
        check("cold_latency", k, 32'd5);

        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid_o && pc_o == 32'hC) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("wait_pc12");

        // Redirect to 0 in LOOKUP: bubble, then a hot loop with no memory traffic.
        jump_addr_i = 32'h0;
        jump_i      = 1'b1;
        @(posedge clk);
        #1;
        jump_i = 1'b0;
        check("bubble_valid", {31'd0, inst_valid_o}, 32'd0);
        check("bubble_inst", inst_o, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("hot_valid", {31'd0, inst_valid_o}, 32'd1);
            check("hot_noreq", {31'd0, mem_req_o}, 32'd0);
        end

        jump_i = 1'b1;
        @(posedge clk);
        #1;
        jump_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_pc", pc_o, 32'h4);
            check("stall_inst", inst_o, 32'h0020_0113);
            check("stall_valid", {31'd0, inst_valid_o}, 32'd1);
            check("stall_noreq", {31'd0, mem_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        lat     = 10;
        @(posedge clk);
        #1;
        check("resume_pc", pc_o, 32'h8);

        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (mem_req_o) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("wait_req16");

        // Reset in the middle of an outstanding request.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_req", {31'd0, mem_req_o}, 32'd0);
        check("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_pred", prediction_o, 32'h0);
        rst  = 1'b0;
        lat  = 3;
        jal8 = 1'b1;

        push_exp(32'h0,  32'h0010_0093, 32'h4);
        push_exp(32'h40, 32'h0004_0013, 32'h44);
        push_exp(32'h4,  32'h0020_0113, 32'h8);
        push_exp(32'h8,  32'h0100_006F, 32'h18);
        push_exp(32'h18, 32'h0001_8013, 32'h1C);
        req_q.push_back(32'h0);
        req_q.push_back(32'h4);
        req_q.push_back(32'h40);
        req_q.push_back(32'h8);
        req_q.push_back(32'h18);
        req_q.push_back(32'h1C);

        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mem_req_o && mem_addr_o == 32'h4) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("wait_req4");

        // Redirect while the miss on 4 is outstanding: drain it, fetch 0x40 next.
        jump_addr_i = 32'h40;
        jump_i      = 1'b1;
        @(posedge clk);
        #1;
        jump_i = 1'b0;
        for (int i = 0; i < 20 && mem_req_o; i++) begin
            check("drain_invalid", {31'd0, inst_valid_o}, 32'd0);
            @(posedge clk);
            #1;
        end

        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid_o && pc_o == 32'h40) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("wait_pc40");

        jump_addr_i = 32'h4;
        jump_i      = 1'b1;
        @(posedge clk);
        #1;
        jump_i = 1'b0;
        @(posedge clk);
        #1;
        check("drained_hit_valid", {31'd0, inst_valid_o}, 32'd1);
        check("drained_hit_pc", pc_o, 32'h4);
        check("drained_hit_noreq", {31'd0, mem_req_o}, 32'd0);

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout_fail("wait_outputs_done");
        check("req_q_empty", req_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage: holds the PC, looks each fetch up in a small direct-mapped instruction cache, and on a miss runs a request/acknowledge transaction to the memory controller. It delivers one registered {pc, inst, prediction} triple per cycle to the IF/ID register, which feeds the decode stage. It predicts JAL targets statically, falls through to pc+4 otherwise, and honours stall and jump-redirect from later stages.

## Interface
- ICACHE_ENTRIES, 16, number of one-word cache lines; power of two, at least 2
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset rst, synchronous, active-high
- stall_i  in  1  downstream not ready; hold the outputs and the PC
- jump_i  in  1  redirect from a later stage (mispredict or JALR)
- jump_addr_i  in  32  redirect target
- mem_req_o  out  1  memory read request
- mem_addr_o  out  32  word address of the request; bits [1:0] are always 0
- mem_ack_i  in  1  single-cycle acknowledge; mem_data_i is valid in this cycle
- mem_data_i  in  32  fetched instruction word
- pc_o  out  32  address of inst_o
- inst_o  out  32  instruction; 32'h0000_0013 (NOP) when not valid
- inst_valid_o  out  1  inst_o is a real instruction
- prediction_o  out  32  predicted next PC for pc_o

## Operation
- Cache geometry:
  - IW = log2(ICACHE_ENTRIES).
  - Index = pc[IW+1:2]; tag = pc[31:IW+2].
  - Each line holds {valid, tag, data}.
  - Reset clears all valid bits; tag and data contents are not reset.
- PC bits [1:0] are forced to 0 on every load.
- Prediction:
  - If inst[6:0] == 7'b1101111 (JAL), prediction = pc + sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Otherwise prediction = pc + 4, modulo 2^32 (wraps at 32'hFFFF_FFFC).
  - The next fetch PC is the prediction.
- FSM states: LOOKUP, MISS, DRAIN.
  - LOOKUP, hit, no stall: register the outputs (valid=1) and set pc to the prediction.
  - LOOKUP, miss: go to MISS. Assert mem_req_o and drive mem_addr_o = pc from the next cycle on.
  - MISS: hold mem_req_o=1 and mem_addr_o stable until mem_ack_i. On ack:
    - write the line;
    - register the outputs with mem_data_i (valid=1, unless stalled);
    - advance pc;
    - return to LOOKUP.
  - DRAIN: entered when jump_i arrives during MISS. The outstanding request is never aborted.
    - On ack, write the line, discard the word, load pc from the saved redirect target, and return to LOOKUP.
    - Outputs stay invalid throughout DRAIN.
    - A second jump_i in DRAIN overwrites the saved target.
- jump_i in LOOKUP:
  - pc <= jump_addr_i;
  - the registered outputs become a bubble (valid=0, inst=NOP) at the next edge.
- Priority: rst > jump_i > stall_i > normal fetch.
- stall_i=1 without jump:
  - outputs, pc and state are frozen;
  - in MISS the request continues. An ack while stalled fills the cache but does not advance pc; the next lookup then hits.
- Reset:
  - pc=RESET_PC, state LOOKUP, mem_req_o=0, mem_addr_o=0;
  - pc_o=0, inst_o=32'h0000_0013, inst_valid_o=0, prediction_o=0.
- Reset mid-miss drops the request immediately. mem_req_o is 0 in the cycle after the rst edge, and a late ack is ignored.

## Timing
- Hit: the outputs for PC p appear at the edge after p is presented. Sustained throughput is 1 instruction/cycle.
- Miss:
  - mem_req_o rises 1 cycle after the failed lookup.
  - The outputs are valid at the edge following the mem_ack_i cycle.
  - Total latency = 2 + memory wait cycles.
- Redirect: bubble at the next edge; target instruction at the following edge if it hits.
- mem_ack_i while mem_req_o=0 is ignored.
- Lookup, cache write and output registration all use the edge; a fill is visible to the lookup in the next cycle.

## Test plan
- Cold start, RESET_PC=0, memory word0=32'h0010_0093, ack after 3 cycles:
  - mem_req_o=1 with addr 0 until the ack;
  - then pc_o=0, inst_o=32'h0010_0093, valid=1, prediction_o=4.
- Hot loop: refetch addresses 0..12 after fill -> 4 consecutive valid outputs on 4 consecutive cycles, no mem_req_o.
- JAL at pc 8, word 32'h0100_006F -> prediction_o=32'h18; next fetch addr 32'h18.
- jump_i to 32'h40 during MISS on pc 4:
  - the request completes;
  - inst_valid_o stays 0;
  - the next request addr is 32'h40;
  - line 1 is filled (a later fetch of 4 hits).
- stall_i held 5 cycles during hits -> outputs and pc unchanged; resumes with the next sequential instruction.
- rst asserted while mem_req_o=1 -> mem_req_o=0 the next cycle; all valid bits cleared (addr 0 misses again).
